mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, with architectural HI/LO registers.
- Sits in the EX stage beside the ALU. Takes operands and the start command from the ID/EX register, after the forwarding muxes.
- HI/LO feed the EX/MEM path for MFHI/MFLO.
- Raises busy, which the hazard unit uses to stall the pipeline until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  command valid; sampled only while busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write a into HI
- mtlo  input  1  write a into LO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight; stall request to hazard unit
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- div_by_zero  output  1  last DIV/DIVU had b==0

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. This applies in any state and aborts an operation in flight with no HI/LO update.
- States: IDLE, RUN, FIXUP.
- IDLE, on an edge with start=1 (edge E0):
  - latch op and the operand magnitudes; for signed ops also latch sign(a), sign(b) and their XOR;
  - clear counter; go to RUN; busy=1 from the cycle after E0;
  - div_by_zero is updated at E0: 1 if op is DIV/DIVU and b==0, else 0.
- RUN: one radix-2 iteration per edge, E1..E32 (WIDTH iterations). Counter increments each edge; at counter==WIDTH-1 the next state is FIXUP.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring shift-subtract; remainder register WIDTH+1 bits.
- FIXUP (edge E33):
  - apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the sign of the dividend;
  - write HI/LO: mult gives hi=product[2W-1:W], lo=product[W-1:0]; div gives lo=quotient, hi=remainder;
  - go to IDLE; busy=0 and done=1 in the cycle after E33; done clears the following cycle.
- Total latency: 33 edges from start sample to HI/LO valid; busy is high for exactly 33 cycles.
- Divide by zero: iterate normally but commit hi=a (original dividend), lo={WIDTH{1}}.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- start while busy=1: ignored; not queued.
- mthi/mtlo:
  - honoured only in IDLE with start=0; written at the edge, visible next cycle;
  - ignored while busy;
  - if start=1 in the same IDLE cycle, start wins and mthi/mtlo are dropped;
  - mthi and mtlo together write both registers with a.
- hi/lo hold their value during RUN; they are never partially updated.
- Operands are captured at E0; later changes on a/b have no effect.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined: MULT/MULTU complete in a single cycle using a combinational signed/unsigned WIDTH×WIDTH multiply.
  - hi/lo are written at E0; done=1 in the cycle after E0; busy never asserts for multiplies.
  - DIV/DIVU are unchanged (33-cycle iterative).
- Undefined: all four ops use the iterative path described above.

Test Plan:
- Reset with reset=0 for 2 cycles, then start=1 op=MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy=1 for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MDU_FAST_MULT_EN the same values appear with done one cycle after start and busy=0 throughout.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF after 33 cycles; the next MULTU clears div_by_zero.
- Mid-operation events: start=1 again at cycle 10 of a DIV -> ignored, result unchanged; reset=0 at cycle 20 of a MULT -> hi=lo=0, busy=0, done never pulses.
- In IDLE, mthi=1 a=0xCAFEBABE -> hi=0xCAFEBABE next cycle. The same write attempted while busy -> hi unchanged. mtlo=1 with start=1 in the same cycle -> operation starts, lo is not written by mtlo.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers.
// One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract
// for divide, then a single FIXUP cycle for sign correction and the HI/LO commit.
// Optional: define MDU_FAST_MULT_EN to finish MULT/MULTU in one cycle with a
// combinational multiplier; DIV/DIVU stay iterative either way.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;   // dividend sign, drives remainder sign
    logic               neg_q, neg_d;         // sign(a) ^ sign(b)
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   orig_a_q, orig_a_d;   // raw dividend for the divide-by-zero commit
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Operand conditioning at start: op[0]==0 marks the signed ops.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   start_mag_a, start_mag_b;

    assign a_neg       = ~op[0] & a[WIDTH-1];
    assign b_neg       = ~op[0] & b[WIDTH-1];
    assign start_mag_a = a_neg ? -a : a;
    assign start_mag_b = b_neg ? -b : b;

    // Per-iteration datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_trial = div_shift - {2'b00, mag_b_q};
    assign prod_fix  = neg_q ? -prod_q : prod_q;
    assign quo_fix   = neg_q ? -quo_q : quo_q;
    assign rem_fix   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef MDU_FAST_MULT_EN
    // Low 2W bits of the product of sign/zero-extended operands equal the
    // signed/unsigned W x W product.
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = op[0] ? ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b})
                             : ({{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b});
`endif

    // Next-state and datapath update for IDLE/RUN/FIXUP.
    always_comb begin
        // NOTE: every _d takes its held value first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        orig_a_d = orig_a_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = a_neg;
                    neg_d    = a_neg ^ b_neg;
                    mag_a_d  = start_mag_a;
                    mag_b_d  = start_mag_b;
                    orig_a_d = a;
                    cnt_d    = '0;
                    prod_d   = {{WIDTH{1'b0}}, start_mag_b};
                    rem_d    = '0;
                    quo_d    = start_mag_a;
                    dbz_d    = op[1] && (b == '0);
                    state_d  = RUN;
`ifdef MDU_FAST_MULT_EN
                    if (!op[1]) begin
                        hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                        lo_d    = fast_prod[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end

            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    // Restoring step: keep the trial difference only if it did not go negative.
                    rem_d = div_trial[WIDTH+1] ? div_shift[WIDTH:0] : div_trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIXUP;
            end

            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (dbz_q) begin
                        hi_d = orig_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            orig_a_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            orig_a_q <= orig_a_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO/div_by_zero come from a
// behavioural model, are queued when an op is issued and popped on done.
// Honours MDU_FAST_MULT_EN for multiply latency expectations.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    exp_t        sb_q[$];
    logic [31:0] model_hi, model_lo;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h required %h", tag, got, exp);
        else pass_cnt++;
    endtask

    // Reference results from plain integer arithmetic.
    function automatic exp_t ref_model(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        e = '0;
        case (op_v)
            OP_MULT: begin
                p = {{32{a_v[31]}}, a_v} * {{32{b_v[31]}}, b_v};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a_v} * {32'd0, b_v};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b_v == 32'd0) begin
                    e.dbz = 1'b1;
                    e.hi  = a_v;
                    e.lo  = 32'hFFFF_FFFF;
                end else if (op_v == OP_DIV) begin
                    sa = {{32{a_v[31]}}, a_v};
                    sb = {{32{b_v[31]}}, b_v};
                    q  = sa / sb;
                    r  = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a_v / b_v;
                    e.hi = a_v % b_v;
                end
            end
        endcase
        return e;
    endfunction

    // disturb: 0 none, 1 restart at busy cycle 10, 2 mthi+mtlo at busy cycle 10,
    //          3 mtlo asserted together with start.
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input int disturb);
        exp_t e;
        int   busy_cycles;
        bit   seen;
        bit   fast_op;
        fast_op = FAST && !op_v[1];
        @(negedge clk);
        op    = op_v;
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        mtlo  = (disturb == 3);
        sb_q.push_back(ref_model(op_v, a_v, b_v));
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        if (disturb == 3 && !fast_op) check({tag, "_mtlo_dropped"}, lo, model_lo);
        busy_cycles = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (cyc == 5) check({tag, "_hold_hi"}, hi, model_hi);
                if (cyc == 11 && disturb == 2) check({tag, "_mt_busy_hi"}, hi, model_hi);
                if (cyc == 10 && disturb == 1) begin
                    start = 1'b1;
                    op    = OP_MULTU;
                    a     = $urandom;
                    b     = $urandom;
                end else if (cyc == 10 && disturb == 2) begin
                    mthi = 1'b1;
                    mtlo = 1'b1;
                    a    = 32'hDEAD_BEEF;
                end else begin
                    start = 1'b0;
                    mthi  = 1'b0;
                    mtlo  = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        e = sb_q.pop_front();
        if (seen) begin
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
            check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
            check({tag, "_busy_cycles"}, 64'(busy_cycles), fast_op ? 64'd0 : 64'd33);
        end
        model_hi = e.hi;
        model_lo = e.lo;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit          seen_done;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        model_hi = '0;
        model_lo = '0;

        repeat (2) @(negedge clk);
        check("rst_hi", hi, 64'd0);
        check("rst_lo", lo, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 0);
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 0);
        run_op("multu_clr", OP_MULTU, 32'd3, 32'd5, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_zero_s", OP_DIV, 32'hFFFF_FF00, 32'd0, 0);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_mix", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("div_negneg", OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = $urandom;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
        end

        run_op("div_restart", OP_DIV, 32'd1000, 32'hFFFF_FFF3, 1);

        // mthi in IDLE
        @(negedge clk);
        mthi = 1'b1;
        a    = 32'hCAFE_BABE;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_idle_hi", hi, 64'hCAFE_BABE);
        check("mthi_idle_lo", lo, model_lo);
        model_hi = 32'hCAFE_BABE;

        run_op("divu_mt_busy", OP_DIVU, 32'd100, 32'd7, 2);
        run_op("multu_mtlo_start", OP_MULTU, 32'd3, 32'd5, 3);

        // mthi and mtlo together
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        a    = 32'h5A5A_5A5A;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mt_both_hi", hi, 64'h5A5A_5A5A);
        check("mt_both_lo", lo, 64'h5A5A_5A5A);

        // Reset in the middle of an iterative operation.
        @(negedge clk);
        start = 1'b1;
        op    = FAST ? OP_DIVU : OP_MULT;
        a     = 32'h1234_5678;
        b     = 32'h0000_0009;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_hi", hi, 64'd0);
        check("abort_lo", lo, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_hi_after", hi, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
